// File: rtl/dut_or_fifo_if.sv
// dut_or_fifo_if: register-style write and read ports of the OR engine.
// Latency: none, plain wires; read_data is combinational in the slave.
// Backpressure: write_rdy / read_rdy gate write_en / read_en.
interface dut_or_fifo_if;
    logic [2:0] write_address;
    logic       write_data;
    logic       write_en;
    logic       write_rdy;
    logic [2:0] read_address;
    logic       read_en;
    logic       read_data;
    logic       read_rdy;

    modport master (
        output write_address,
        output write_data,
        output write_en,
        input  write_rdy,
        output read_address,
        output read_en,
        input  read_data,
        input  read_rdy
    );

    modport slave (
        input  write_address,
        input  write_data,
        input  write_en,
        output write_rdy,
        input  read_address,
        input  read_en,
        output read_data,
        output read_rdy
    );
endinterface

// File: rtl/dut_or_fifo.sv
// dut_or_fifo: 1-bit OR of two 2-deep input FIFOs (A, B) into a 1-deep result FIFO (Y).
// Latency: both operands present -> OR fires at the next edge -> Y readable the cycle after.
// Backpressure: OR stalls while Y is full and unpopped; writes to a full A/B are dropped.
// Optional DELAYED_RDY_EN: each accepted transaction drops that port's rdy for one cycle.
module dut_or_fifo (
    input  logic         CLK,
    input  logic         RST_N,
    dut_or_fifo_if.slave bus
);
    localparam logic [2:0] ADDR_A_STATUS = 3'd0;
    localparam logic [2:0] ADDR_B_STATUS = 3'd1;
    localparam logic [2:0] ADDR_Y_STATUS = 3'd2;
    localparam logic [2:0] ADDR_Y_OUTPUT = 3'd3;
    localparam logic [2:0] ADDR_A_DATA   = 3'd4;
    localparam logic [2:0] ADDR_B_DATA   = 3'd5;

    // Two-entry FIFO storage: bit 0 is the head, count is 0..2.
    logic [1:0] a_mem, a_mem_nxt, a_cnt, a_cnt_nxt;
    logic [1:0] b_mem, b_mem_nxt, b_cnt, b_cnt_nxt;
    logic       a_full, a_empty, b_full, b_empty;
    logic       a_push, a_pop, b_push, b_pop;

    // One-entry result FIFO.
    logic       y_vld, y_dat;
    logic       y_pop, y_can_accept;

    logic       write_acc, read_acc, or_fire;

    // Next state of a 2-deep shift FIFO with simultaneous push/pop.
    function automatic logic [1:0] fifo2_mem_nxt(input logic [1:0] mem,
                                                 input logic [1:0] cnt,
                                                 input logic       push,
                                                 input logic       pop,
                                                 input logic       din);
        logic [1:0] m;
        logic [1:0] idx;
        m = mem;
        if (pop) begin
            m = {1'b0, mem[1]};
        end
        idx = cnt - {1'b0, pop};
        if (push) begin
            if (idx == 2'd0) begin
                m[0] = din;
            end else begin
                m[1] = din;
            end
        end
        return m;
    endfunction

    assign a_full  = (a_cnt == 2'd2);
    assign a_empty = (a_cnt == 2'd0);
    assign b_full  = (b_cnt == 2'd2);
    assign b_empty = (b_cnt == 2'd0);

`ifdef DELAYED_RDY_EN
    logic wr_block_q;
    logic rd_block_q;

    // Blank each port for the cycle right after it accepts a transaction.
    always_ff @(posedge CLK or posedge RST_N) begin
        if (RST_N) begin
            wr_block_q <= 1'b0;
            rd_block_q <= 1'b0;
        end else begin
            wr_block_q <= write_acc;
            rd_block_q <= read_acc;
        end
    end

    assign bus.write_rdy = !RST_N && !wr_block_q;
    assign bus.read_rdy  = !RST_N && !rd_block_q;
`else
    assign bus.write_rdy = !RST_N;
    assign bus.read_rdy  = !RST_N;
`endif

    assign write_acc = bus.write_en && bus.write_rdy;
    assign read_acc  = bus.read_en  && bus.read_rdy;

    // Popping Y by software frees the slot for a same-cycle OR result.
    assign y_pop        = read_acc && (bus.read_address == ADDR_Y_OUTPUT) && y_vld;
    assign y_can_accept = !y_vld || y_pop;
    assign or_fire      = !a_empty && !b_empty && y_can_accept;

    assign a_pop  = or_fire;
    assign b_pop  = or_fire;
    // A write into a full FIFO still lands if the OR stage pops it this cycle.
    assign a_push = write_acc && (bus.write_address == ADDR_A_DATA) && (!a_full || a_pop);
    assign b_push = write_acc && (bus.write_address == ADDR_B_DATA) && (!b_full || b_pop);

    // Next-state of the input FIFOs.
    always_comb begin
        a_mem_nxt = fifo2_mem_nxt(a_mem, a_cnt, a_push, a_pop, bus.write_data);
        b_mem_nxt = fifo2_mem_nxt(b_mem, b_cnt, b_push, b_pop, bus.write_data);
        a_cnt_nxt = a_cnt + {1'b0, a_push} - {1'b0, a_pop};
        b_cnt_nxt = b_cnt + {1'b0, b_push} - {1'b0, b_pop};
    end

    // Input FIFO state registers.
    always_ff @(posedge CLK or posedge RST_N) begin
        if (RST_N) begin
            a_mem <= 2'b00;
            a_cnt <= 2'd0;
            b_mem <= 2'b00;
            b_cnt <= 2'd0;
        end else begin
            a_mem <= a_mem_nxt;
            a_cnt <= a_cnt_nxt;
            b_mem <= b_mem_nxt;
            b_cnt <= b_cnt_nxt;
        end
    end

    // Result FIFO: an OR result takes priority over emptying since pop frees the slot.
    always_ff @(posedge CLK or posedge RST_N) begin
        if (RST_N) begin
            y_vld <= 1'b0;
            y_dat <= 1'b0;
        end else if (or_fire) begin
            y_vld <= 1'b1;
            y_dat <= a_mem[0] | b_mem[0];
        end else if (y_pop) begin
            y_vld <= 1'b0;
            y_dat <= 1'b0;
        end
    end

    // Read mux; forced low during reset and for unmapped addresses.
    always_comb begin
        bus.read_data = 1'b0;
        if (!RST_N) begin
            case (bus.read_address)
                ADDR_A_STATUS: bus.read_data = !a_full;
                ADDR_B_STATUS: bus.read_data = !b_full;
                ADDR_Y_STATUS: bus.read_data = y_vld;
                ADDR_Y_OUTPUT: bus.read_data = y_vld & y_dat;
                default:       bus.read_data = 1'b0;
            endcase
        end
    end
endmodule

// File: tb/tb_dut_or_fifo.sv
// tb_dut_or_fifo: directed stimulus with a read scoreboard for dut_or_fifo.
// Reads push their expected value; a negedge monitor compares on each accepted read.
// Handshake and reset levels are checked directly at the point they are defined.
module tb_dut_or_fifo;
    logic CLK;
    logic RST_N;

    dut_or_fifo_if bus ();

    dut_or_fifo u_dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    int    errors = 0;
    int    checks = 0;
    int    exp_q[$];
    string name_q[$];

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Scoreboard monitor: compare every accepted read against the queued expectation.
    always @(negedge CLK) begin
        if (!RST_N && bus.read_en && bus.read_rdy) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL rd_unexpected: got %0b, nothing expected", bus.read_data);
            end else begin
                int    e;
                string n;
                e = exp_q.pop_front();
                n = name_q.pop_front();
                if (bus.read_data !== e[0]) begin
                    errors++;
                    $display("FAIL %s: got %0b, expected %0b", n, bus.read_data, e[0]);
                end
            end
        end
    end

    task automatic chk(input string n, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b, expected %0b", n, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic d);
        int n;
        n = 0;
        while (!bus.write_rdy && n < 20) begin
            idle(1);
            n++;
        end
        if (!bus.write_rdy) begin
            checks++;
            errors++;
            $display("FAIL wr_timeout: write_rdy got 0, expected 1");
        end
        bus.write_en      = 1'b1;
        bus.write_address = a;
        bus.write_data    = d;
        idle(1);
        bus.write_en = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, input logic e, input string n);
        int k;
        k = 0;
        while (!bus.read_rdy && k < 20) begin
            idle(1);
            k++;
        end
        if (!bus.read_rdy) begin
            checks++;
            errors++;
            $display("FAIL rd_timeout %s: read_rdy got 0, expected 1", n);
        end
        bus.read_en      = 1'b1;
        bus.read_address = a;
        exp_q.push_back(int'(e));
        name_q.push_back(n);
        idle(1);
        bus.read_en = 1'b0;
    endtask

    task automatic do_reset();
        RST_N = 1'b1;
        idle(2);
        RST_N = 1'b0;
        #1;
    endtask

    // Watchdog so a stuck handshake still ends the run.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit [3:0] combo_a;
        bit [3:0] combo_b;
        bit [3:0] combo_y;
        combo_a = 4'b1100;
        combo_b = 4'b1010;
        combo_y = 4'b1110;

        RST_N             = 1'b1;
        bus.write_en      = 1'b0;
        bus.write_address = 3'd0;
        bus.write_data    = 1'b0;
        bus.read_en       = 1'b0;
        bus.read_address  = 3'd0;

        // Reset state.
        idle(2);
        chk("rst_write_rdy", bus.write_rdy, 1'b0);
        chk("rst_read_rdy",  bus.read_rdy,  1'b0);
        bus.read_address = 3'd0;
        #1;
        chk("rst_read_data", bus.read_data, 1'b0);
        RST_N = 1'b0;
        #1;
        chk("post_rst_write_rdy", bus.write_rdy, 1'b1);
        chk("post_rst_read_rdy",  bus.read_rdy,  1'b1);
        rd(3'd0, 1'b1, "a_status_empty");
        rd(3'd1, 1'b1, "b_status_empty");
        rd(3'd2, 1'b0, "y_status_empty");
        rd(3'd3, 1'b0, "y_output_empty");
        rd(3'd2, 1'b0, "y_status_after_empty_pop");
        rd(3'd6, 1'b0, "unmapped_read_6");

        // Ignored write addresses leave A/B/Y untouched.
        wr(3'd0, 1'b1);
        wr(3'd6, 1'b1);
        wr(3'd7, 1'b1);
        idle(2);
        rd(3'd2, 1'b0, "ignored_writes_y_status");

        // Basic path with the minimum-latency read.
        wr(3'd4, 1'b1);
        wr(3'd5, 1'b0);
        idle(1);
        rd(3'd2, 1'b1, "basic_y_status");
        rd(3'd3, 1'b1, "basic_y_output");
        rd(3'd2, 1'b0, "basic_y_status_drained");

        // All four operand combinations, in order.
        for (int i = 0; i < 4; i++) begin
            wr(3'd4, combo_a[3 - i]);
            wr(3'd5, combo_b[3 - i]);
            idle(2);
            rd(3'd3, combo_y[3 - i], $sformatf("combo_%0d", i));
        end

        // Write to a full A in the same cycle the OR stage pops A.
        wr(3'd4, 1'b0);
        wr(3'd4, 1'b0);
        rd(3'd0, 1'b0, "a_full_status");
        wr(3'd5, 1'b1);
        wr(3'd4, 1'b1);
        idle(2);
        rd(3'd3, 1'b1, "pop_push_first_or");
        rd(3'd0, 1'b0, "pop_push_a_still_full");
        wr(3'd5, 1'b0);
        idle(2);
        rd(3'd3, 1'b0, "pop_push_second_or");
        wr(3'd5, 1'b0);
        idle(2);
        rd(3'd3, 1'b1, "pop_push_written_bit");
        rd(3'd0, 1'b1, "pop_push_a_drained");

        // Fill Y and both input FIFOs, then a dropped write to A.
        wr(3'd4, 1'b0);
        wr(3'd5, 1'b0);
        idle(2);
        wr(3'd4, 1'b1);
        wr(3'd4, 1'b0);
        wr(3'd5, 1'b0);
        wr(3'd5, 1'b0);
        idle(2);
        rd(3'd0, 1'b0, "full_a_status");
        rd(3'd1, 1'b0, "full_b_status");
        rd(3'd2, 1'b1, "full_y_status");
        wr(3'd4, 1'b1);
        rd(3'd3, 1'b0, "drain_0");
        rd(3'd3, 1'b1, "drain_1");
        rd(3'd3, 1'b0, "drain_2");
        rd(3'd2, 1'b0, "drain_y_empty");
        wr(3'd5, 1'b0);
        idle(2);
        rd(3'd2, 1'b0, "dropped_bit_absent");
        rd(3'd1, 1'b1, "b_one_entry_status");

        // Reset in the middle of traffic.
        wr(3'd4, 1'b1);
        wr(3'd4, 1'b1);
        wr(3'd5, 1'b0);
        RST_N = 1'b1;
        bus.read_address = 3'd2;
        #1;
        chk("midrst_write_rdy", bus.write_rdy, 1'b0);
        chk("midrst_read_rdy",  bus.read_rdy,  1'b0);
        chk("midrst_read_data", bus.read_data, 1'b0);
        idle(2);
        RST_N = 1'b0;
        #1;
        rd(3'd0, 1'b1, "midrst_a_status");
        rd(3'd1, 1'b1, "midrst_b_status");
        rd(3'd2, 1'b0, "midrst_y_status");
        rd(3'd3, 1'b0, "midrst_y_output");

`ifdef DELAYED_RDY_EN
        // Back-to-back writes: only cycles 1 and 3 are taken (both to A).
        do_reset();
        idle(1);
        for (int i = 0; i < 4; i++) begin
            bus.write_en      = 1'b1;
            bus.write_address = (i % 2 == 0) ? 3'd4 : 3'd5;
            bus.write_data    = (i == 0) ? 1'b1 : 1'b0;
            #1;
            chk($sformatf("delayed_write_rdy_%0d", i), bus.write_rdy, (i % 2 == 0));
            idle(1);
        end
        bus.write_en = 1'b0;
        idle(2);
        rd(3'd0, 1'b0, "delayed_a_full");
        rd(3'd1, 1'b1, "delayed_b_empty");
        rd(3'd2, 1'b0, "delayed_y_empty");
`else
        // Without blanking, rdy holds high across back-to-back writes.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            bus.write_en      = 1'b1;
            bus.write_address = (i % 2 == 0) ? 3'd4 : 3'd5;
            bus.write_data    = (i == 0) ? 1'b1 : 1'b0;
            #1;
            chk($sformatf("steady_write_rdy_%0d", i), bus.write_rdy, 1'b1);
            idle(1);
        end
        bus.write_en = 1'b0;
        idle(2);
        rd(3'd3, 1'b1, "steady_or_0");
        rd(3'd3, 1'b0, "steady_or_1");
`endif

        idle(3);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending reads, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
